pixel_stream_src: RTL and testbench
===================================

// Module: pixel_stream_src
// PURPOSE
//  Parametrised frame source: reads a packed-RGB image from a synchronous external pixel memory, applies a
//  runtime-selected point operation and emits pixels on a valid/ready stream with sof/eol/eof flags.
//  Generates frame/line blanking timing (VSYNC/HSYNC) and supports single-shot or continuous frames.
//  Sits between the image memory and the downstream processing/writer blocks of the image pipeline.
// PARAMETERS
//  WIDTH        768  pixels per line (>=2)
//  HEIGHT       512  lines per frame (>=1)
//  DW           8    bits per colour channel
//  ADDR_W       19   memory address width, 2**ADDR_W >= WIDTH*HEIGHT
//  VBLANK       100  idle cycles before first line of a frame
//  HBLANK       160  idle cycles before every line
//  BOTTOM_UP    1    1: memory row 0 is bottom image line (line y read from row HEIGHT-1-y); 0: top-first
//  CONTINUOUS   0    1: restart a new frame automatically after eof; 0: return to IDLE
//  FIFO_DEPTH   4    output buffer entries (power of 2, >=2)
// PORTS
//  HCLK        in   1       clock
//  HRESET      in   1       asynchronous reset, active-high
//  start       in   1       pulse: begin a frame (ignored unless IDLE)
//  mode        in   3       0 pass,1 bright add,2 bright sub,3 invert gray,4 threshold,5-7 = pass
//  value       in   DW      brightness offset
//  threshold   in   DW      threshold level
//  mem_addr    out  ADDR_W  pixel word address
//  mem_rd      out  1       read strobe; mem_data valid exactly 1 cycle later
//  mem_data    in   3*DW    {R,G,B}
//  out_valid   out  1       stream valid
//  out_ready   in   1       stream ready
//  out_r/g/b   out  DW each processed pixel
//  out_sof/out_eol/out_eof out 1 each  first pixel of frame / last of line / last of frame
//  VSYNC       out  1       high while in VBLANK
//  HSYNC       out  1       high while in ACTIVE (line being read)
//  busy        out  1       high whenever state != IDLE or FIFO non-empty
//  done        out  1       1-cycle pulse on the cycle the eof pixel handshakes
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, counters 0, state IDLE; reset mid-frame aborts, no done pulse.
//  FSM: IDLE -start-> VBLANK (VBLANK cycles) -> HBLANK (HBLANK cycles) -> ACTIVE (WIDTH reads issued)
//   -> HBLANK if more lines, else DRAIN; DRAIN -> (FIFO empty & no read in flight) -> IDLE, or VBLANK if
//   CONTINUOUS. VBLANK=0/HBLANK=0 means the state lasts 1 cycle.
//  mode/value/threshold sampled on frame start (IDLE/DRAIN->VBLANK); constant for the whole frame.
//  Reads: in ACTIVE, mem_rd=1 only when FIFO occupancy + reads in flight < FIFO_DEPTH; x advances only on
//   an issued read, so ACTIVE stretches under backpressure; blanking counters never stall.
//  Address = row*WIDTH + x, row = BOTTOM_UP ? HEIGHT-1-y : y.
//  Pipeline: mem_data captured and processed 1 cycle after mem_rd, written into FIFO that cycle; earliest
//   out_valid is 2 cycles after the first mem_rd. Flags computed at issue time and carried with pixel.
//  Ops per channel c (unsigned, DW+1-bit intermediates): add: min(c+value, 2**DW-1); sub: max(c-value,0);
//   gray g=(R+2G+B)>>2 (DW+2 bits); invert: all channels = (2**DW-1)-g;
//   threshold: all = (g>threshold) ? 2**DW-1 : 0 (equal -> 0).
//  Stream: out_* stable while out_valid & !out_ready; FIFO pop on out_valid&out_ready; push and pop in the
//   same cycle allowed at any occupancy, including full. No pixel dropped or duplicated.
//  start while busy ignored; start in same cycle as last pop ignored (state not yet IDLE).
// STRUCTURE
//  Package pixel_stream_pkg: mode encodings, FSM state enum, gray/saturate function.
//  Sub-module pix_fifo (synchronous FIFO, width 3*DW+3, depth FIFO_DEPTH, count output).
//  Top: FSM, blanking/x/y counters, address gen, in-flight flag, op stage.
// TESTING
//  WIDTH=4,HEIGHT=2,VBLANK=3,HBLANK=2,mode 0, ready=1, ramp mem -> 8 pixels in order, BOTTOM_UP row swap
//   (addr 4..7 then 0..3), sof on 1st, eol on 4th/8th, eof+done on 8th, back to IDLE.
//  mode 1 value 100 on R=200,G=155,B=10 -> 255,255,110; mode 2 value 100 -> 100,55,0.
//  mode 4 threshold 90: g=90 -> 0,0,0; g=91 -> 255 all; mode 3 on g=91 -> 164 all.
//  Random out_ready (30% duty) -> output identical to ready=1 run; mem_rd never with FIFO+inflight full.
//  Reset asserted mid-line 2 -> outputs 0 next cycle, no done; new start gives full correct frame.
//  CONTINUOUS=1: two frames back-to-back, sof repeats, mode change mid-frame applies only to frame 2.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared encodings and per-pixel arithmetic for the pixel stream source.
// Latency: n/a (constants and combinational helper functions only).
// Backpressure: n/a.
package pixel_stream_pkg;

    // Point-operation select; codes 5..7 fall through to pass-through.
    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_ADD  = 3'd1;
    localparam logic [2:0] MODE_SUB  = 3'd2;
    localparam logic [2:0] MODE_INV  = 3'd3;
    localparam logic [2:0] MODE_THR  = 3'd4;

    // Frame sequencer states.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VBLANK = 3'd1;
    localparam logic [2:0] ST_HBLANK = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    // Saturating add, clamped to maxv (channel full-scale).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[31:0];
    endfunction

    // Subtract with floor at zero.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // Luma approximation (R + 2G + B) / 4.
    function automatic logic [31:0] pix_gray(input logic [31:0] r, input logic [31:0] g,
                                             input logic [31:0] b);
        return (r + (g << 1) + b) >> 2;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: push visible at head the cycle after it is written.
// Backpressure: push accepted when not full or when popping in the same cycle.
module pix_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_src.sv
// Frame source: memory reads -> point op -> buffered valid/ready pixel stream with blanking timing.
// Latency: first out_valid 2 cycles after the first mem_rd of a frame.
// Backpressure: reads throttle so buffer + in-flight never exceed FIFO_DEPTH; blanking never stalls.
module pixel_stream_src
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int DW         = 8,
    parameter int ADDR_W     = 19,
    parameter int VBLANK     = 100,
    parameter int HBLANK     = 160,
    parameter int BOTTOM_UP  = 1,
    parameter int CONTINUOUS = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [DW-1:0]     value,
    input  logic [DW-1:0]     threshold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [3*DW-1:0]   mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_r,
    output logic [DW-1:0]     out_g,
    output logic [DW-1:0]     out_b,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic              busy,
    output logic              done
);
    localparam int VB_LEN  = (VBLANK == 0) ? 1 : VBLANK;
    localparam int HB_LEN  = (HBLANK == 0) ? 1 : HBLANK;
    localparam int BLK_MAX = (VB_LEN > HB_LEN) ? VB_LEN : HB_LEN;
    localparam int BCW     = $clog2(BLK_MAX + 1);
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int FW      = 3 * DW + 3;
    localparam logic [31:0] MAXC = 32'((1 << DW) - 1);

    logic [2:0]     state;
    logic [BCW-1:0] blank_cnt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [2:0]     cfg_mode;
    logic [DW-1:0]  cfg_value;
    logic [DW-1:0]  cfg_thr;
    logic           rd_inflight;
    logic           sof_q, eol_q, eof_q;

    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_head;
    logic [FW-1:0]  push_dat;
    logic           fifo_pop;

    logic           last_x, last_y, rd_issue, drain_done, frame_start;
    logic [YW-1:0]  row;
    logic [DW-1:0]  r_in, g_in, b_in, gray_v;
    logic [DW-1:0]  r_op, g_op, b_op;
    logic [DW-1:0]  hd_r, hd_g, hd_b;
    logic           hd_sof, hd_eol, hd_eof;

    assign last_x      = (x == XW'(WIDTH - 1));
    assign last_y      = (y == YW'(HEIGHT - 1));
    assign rd_issue    = (state == ST_ACTIVE) && ((fifo_count + CW'(rd_inflight)) < CW'(FIFO_DEPTH));
    assign drain_done  = fifo_empty && !rd_inflight;
    assign frame_start = ((state == ST_IDLE) && start) ||
                         ((state == ST_DRAIN) && drain_done && (CONTINUOUS != 0));
    assign row         = (BOTTOM_UP != 0) ? (YW'(HEIGHT - 1) - y) : y;

    // Address only driven during a read so the bus idles at zero.
    assign mem_rd   = rd_issue;
    assign mem_addr = rd_issue ? (ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(x)) : '0;

    // Frame sequencer with free-running blanking counters and read-gated x/y.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            blank_cnt <= '0;
            x         <= '0;
            y         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_VBLANK;
                        blank_cnt <= '0;
                    end
                end
                ST_VBLANK: begin
                    if (blank_cnt == BCW'(VB_LEN - 1)) begin
                        state     <= ST_HBLANK;
                        blank_cnt <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (blank_cnt == BCW'(HB_LEN - 1)) begin
                        state     <= ST_ACTIVE;
                        blank_cnt <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (rd_issue) begin
                        if (last_x) begin
                            x <= '0;
                            if (last_y) begin
                                y     <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                y     <= y + 1'b1;
                                state <= ST_HBLANK;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state     <= (CONTINUOUS != 0) ? ST_VBLANK : ST_IDLE;
                        blank_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latch the point-operation configuration once per frame.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cfg_mode  <= MODE_PASS;
            cfg_value <= '0;
            cfg_thr   <= '0;
        end else if (frame_start) begin
            cfg_mode  <= mode;
            cfg_value <= value;
            cfg_thr   <= threshold;
        end
    end

    // Track the read in flight and carry its position flags alongside it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rd_inflight <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            sof_q       <= (x == '0) && (y == '0);
            eol_q       <= last_x;
            eof_q       <= last_x && last_y;
        end
    end

    assign {r_in, g_in, b_in} = mem_data;
    assign gray_v = DW'(pix_gray(32'(r_in), 32'(g_in), 32'(b_in)));

    // Point operation on the returning memory word.
    always_comb begin
        r_op = r_in;
        g_op = g_in;
        b_op = b_in;
        case (cfg_mode)
            MODE_ADD: begin
                r_op = DW'(sat_add(32'(r_in), 32'(cfg_value), MAXC));
                g_op = DW'(sat_add(32'(g_in), 32'(cfg_value), MAXC));
                b_op = DW'(sat_add(32'(b_in), 32'(cfg_value), MAXC));
            end
            MODE_SUB: begin
                r_op = DW'(sat_sub(32'(r_in), 32'(cfg_value)));
                g_op = DW'(sat_sub(32'(g_in), 32'(cfg_value)));
                b_op = DW'(sat_sub(32'(b_in), 32'(cfg_value)));
            end
            MODE_INV: begin
                r_op = DW'(MAXC - 32'(gray_v));
                g_op = r_op;
                b_op = r_op;
            end
            MODE_THR: begin
                r_op = (gray_v > cfg_thr) ? DW'(MAXC) : '0;
                g_op = r_op;
                b_op = r_op;
            end
            default: begin
            end
        endcase
    end

    assign push_dat = {r_op, g_op, b_op, sof_q, eol_q, eof_q};
    assign fifo_pop = out_valid && out_ready;

    pix_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .push     (rd_inflight),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign {hd_r, hd_g, hd_b, hd_sof, hd_eol, hd_eof} = fifo_head;

    // Stream outputs are forced low while nothing is buffered.
    assign out_valid = !fifo_empty;
    assign out_r     = out_valid ? hd_r : '0;
    assign out_g     = out_valid ? hd_g : '0;
    assign out_b     = out_valid ? hd_b : '0;
    assign out_sof   = out_valid && hd_sof;
    assign out_eol   = out_valid && hd_eol;
    assign out_eof   = out_valid && hd_eof;
    assign done      = fifo_pop && hd_eof;
    assign VSYNC     = (state == ST_VBLANK);
    assign HSYNC     = (state == ST_ACTIVE);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pixel_stream_src.sv
module tb_pixel_stream_src;
    logic        HCLK, HRESET;
    logic        start, out_ready, mem_rd, out_valid;
    logic [2:0]  mode;
    logic [7:0]  value, threshold, out_r, out_g, out_b;
    logic [2:0]  mem_addr;
    logic [23:0] mem_data;
    logic        out_sof, out_eol, out_eof, VSYNC, HSYNC, busy, done;

    logic        c_start, c_ready, c_mem_rd, c_valid;
    logic [2:0]  c_mode;
    logic [7:0]  c_value, c_thr, c_r, c_g, c_b;
    logic [2:0]  c_mem_addr;
    logic [23:0] c_mem_data;
    logic        c_sof, c_eol, c_eof, c_VSYNC, c_HSYNC, c_busy, c_done;

    logic [23:0] pmem [8];
    logic [23:0] got_pix [8];
    logic [23:0] got_ref [8];
    int n_checks = 0;
    int n_fail   = 0;

    pixel_stream_src #(.WIDTH(4), .HEIGHT(2), .DW(8), .ADDR_W(3), .VBLANK(3), .HBLANK(2),
                       .BOTTOM_UP(1), .CONTINUOUS(0), .FIFO_DEPTH(4)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .busy(busy), .done(done));

    pixel_stream_src #(.WIDTH(4), .HEIGHT(2), .DW(8), .ADDR_W(3), .VBLANK(3), .HBLANK(2),
                       .BOTTOM_UP(1), .CONTINUOUS(1), .FIFO_DEPTH(4)) u_cont (
        .HCLK(HCLK), .HRESET(HRESET), .start(c_start), .mode(c_mode), .value(c_value),
        .threshold(c_thr), .mem_addr(c_mem_addr), .mem_rd(c_mem_rd), .mem_data(c_mem_data),
        .out_valid(c_valid), .out_ready(c_ready), .out_r(c_r), .out_g(c_g), .out_b(c_b),
        .out_sof(c_sof), .out_eol(c_eol), .out_eof(c_eof), .VSYNC(c_VSYNC), .HSYNC(c_HSYNC),
        .busy(c_busy), .done(c_done));

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Synchronous pixel memory: data one cycle after the read strobe.
    always @(posedge HCLK) begin
        if (mem_rd)   mem_data   <= pmem[mem_addr];
        if (c_mem_rd) c_mem_data <= pmem[c_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference point operation on one {R,G,B} word, written from the arithmetic rules.
    function automatic logic [23:0] ref_pix(input logic [23:0] w, input int m, input int v, input int t);
        int c [3];
        int gy;
        c[0] = int'(w[23:16]); c[1] = int'(w[15:8]); c[2] = int'(w[7:0]);
        gy = (c[0] + 2 * c[1] + c[2]) / 4;
        for (int i = 0; i < 3; i++) begin
            case (m)
                1: c[i] = (c[i] + v > 255) ? 255 : c[i] + v;
                2: c[i] = (c[i] > v) ? c[i] - v : 0;
                3: c[i] = 255 - gy;
                4: c[i] = (gy > t) ? 255 : 0;
                default: ;
            endcase
        end
        return {8'(c[0]), 8'(c[1]), 8'(c[2])};
    endfunction

    function automatic int frame_addr(input int i);
        return (1 - i / 4) * 4 + (i % 4);
    endfunction

    // One frame on u_dut, checked pixel by pixel against the reference.
    task automatic run_frame(input int m, input int v, input int t, input bit rand_rdy, input bit start_on_last);
        logic [23:0] exp_pix [8];
        logic [26:0] cur, prev_out;
        bit prev_stall = 0;
        int n_rd = 0, n_pop = 0, cyc = 0, vs_cnt = 0, first_rd = -1, first_vld = -1;
        for (int i = 0; i < 8; i++) exp_pix[i] = ref_pix(pmem[frame_addr(i)], m, v, t);
        mode = 3'(m); value = 8'(v); threshold = 8'(t);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        // configuration changes after start must not affect this frame
        mode = 3'($urandom); value = 8'($urandom); threshold = 8'($urandom);
        prev_out = '0;
        while (n_pop < 8 && cyc < 2000) begin
            if (VSYNC) vs_cnt++;
            if (mem_rd) begin
                check("rd_gate", 32'((n_rd - n_pop) < 4), 32'd1);
                if (n_rd < 8) check("addr", 32'(mem_addr), 32'(frame_addr(n_rd)));
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
            end
            out_ready = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
            start = start_on_last && out_valid && out_ready && (n_pop == 7);
            #1;
            cur = {out_r, out_g, out_b, out_sof, out_eol, out_eof};
            if (prev_stall) check("stable", 32'(cur), 32'(prev_out));
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                got_pix[n_pop] = cur[26:3];
                check("pix", 32'(cur), 32'({exp_pix[n_pop], n_pop == 0, n_pop % 4 == 3, n_pop == 7}));
                check("done", 32'(done), 32'(n_pop == 7));
                n_pop++;
            end else begin
                check("done_idle", 32'(done), 32'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
            cyc++;
            @(negedge HCLK);
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("pixel_count", 32'(n_pop), 32'd8);
        check("vblank_len", 32'(vs_cnt), 32'd3);
        check("first_latency", 32'(first_vld - first_rd), 32'd2);
        @(negedge HCLK);
        check("back_idle", 32'({busy, VSYNC, HSYNC, out_valid}), 32'd0);
    endtask

    initial begin
        int nr, k, np;
        logic [23:0] e;
        HRESET = 1'b1; start = 1'b0; out_ready = 1'b1; mode = '0; value = '0; threshold = '0;
        c_start = 1'b0; c_ready = 1'b1; c_mode = '0; c_value = '0; c_thr = '0;
        for (int i = 0; i < 8; i++) pmem[i] = 24'(i * 65793 + 24'h102030);
        repeat (3) @(negedge HCLK);
        check("reset_flags", 32'({out_valid, mem_rd, busy, VSYNC, HSYNC, done, out_sof, out_eol, out_eof}), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("idle_bus", 32'({mem_addr, out_r, out_g, out_b}), 32'd0);
        check("idle_busy", 32'({busy, c_busy}), 32'd0);

        // ramp frame, pass-through, start coinciding with the last pop is ignored
        run_frame(0, 0, 0, 1'b0, 1'b1);
        check("start_on_last_ignored", 32'({busy, VSYNC}), 32'd0);

        // saturating add / sub on a known pixel (index 0 reads row 4)
        for (int i = 0; i < 8; i++) pmem[i] = 24'($urandom);
        pmem[4] = {8'd200, 8'd155, 8'd10};
        run_frame(1, 100, 0, 1'b0, 1'b0);
        check("add_sat", 32'(got_pix[0]), 32'({8'd255, 8'd255, 8'd110}));
        run_frame(2, 100, 0, 1'b0, 1'b0);
        check("sub_floor", 32'(got_pix[0]), 32'({8'd100, 8'd55, 8'd0}));

        // threshold boundary (equal -> 0) and invert
        pmem[4] = {3{8'd90}};
        pmem[5] = {3{8'd91}};
        run_frame(4, 0, 90, 1'b0, 1'b0);
        check("thr_equal", 32'(got_pix[0]), 32'd0);
        check("thr_above", 32'(got_pix[1]), 32'h00FF_FFFF);
        run_frame(3, 0, 0, 1'b0, 1'b0);
        check("invert", 32'(got_pix[1]), 32'h00A4_A4A4);

        // random backpressure gives the same stream as ready held high
        for (int r = 0; r < 3; r++) begin
            int m, v, t;
            for (int i = 0; i < 8; i++) pmem[i] = 24'($urandom);
            m = $urandom_range(0, 7); v = $urandom_range(0, 255); t = $urandom_range(0, 255);
            run_frame(m, v, t, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) got_ref[i] = got_pix[i];
            run_frame(m, v, t, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) check("rand_ready_same", 32'(got_pix[i]), 32'(got_ref[i]));
        end

        // reset in the middle of line 2 aborts without done
        mode = 3'd0; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        nr = 0; k = 0;
        while (nr < 5 && k < 500) begin
            if (mem_rd) nr++;
            @(negedge HCLK);
            k++;
        end
        check("reached_line2", 32'(nr), 32'd5);
        HRESET = 1'b1;
        #1;
        check("midreset_flags", 32'({out_valid, mem_rd, busy, VSYNC, HSYNC, done, out_eof}), 32'd0);
        check("midreset_bus", 32'({mem_addr, out_r, out_g, out_b}), 32'd0);
        @(negedge HCLK);
        check("midreset_no_done", 32'(done), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("after_reset_idle", 32'({busy, done}), 32'd0);
        for (int i = 0; i < 8; i++) pmem[i] = 24'($urandom);
        run_frame(1, 37, 0, 1'b1, 1'b0);

        // continuous: two back-to-back frames, mode change lands on frame 2 only
        for (int i = 0; i < 8; i++) pmem[i] = 24'($urandom);
        c_mode = 3'd0; c_start = 1'b1;
        @(negedge HCLK);
        c_start = 1'b0;
        check("cont_vsync", 32'({c_VSYNC, c_HSYNC}), 32'd2);
        np = 0; k = 0;
        while (np < 16 && k < 3000) begin
            if (c_valid) begin
                e = ref_pix(pmem[frame_addr(np % 8)], (np < 8) ? 0 : 3, 0, 0);
                check("cont_pix", 32'({c_r, c_g, c_b, c_sof, c_eol, c_eof}),
                      32'({e, np % 8 == 0, np % 4 == 3, np % 8 == 7}));
                check("cont_done", 32'(c_done), 32'(np % 8 == 7));
                np++;
                if (np == 1) c_mode = 3'd3;
            end
            @(negedge HCLK);
            k++;
        end
        check("cont_count", 32'(np), 32'd16);
        check("cont_still_busy", 32'(c_busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
